// File: rtl/sd_spi_cmd_sequencer.sv
// SPI-mode SD command sequencer for the JC[9:7] PMOD link: 80-clock preamble,
// CRC7-framed 48-bit command, R1 polling with a byte-count timeout.
module sd_spi_cmd_sequencer #(
  parameter int CLK_DIV      = 4,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INIT_REQ,
  input  logic        CMD_REQ,
  input  logic [5:0]  CMD_INDEX,
  input  logic [31:0] CMD_ARG,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  R1,
  output logic        TIMEOUT,
  output logic        SD_SCK,
  output logic        SD_CMD,
  output logic        SD_CS_N,
  input  logic        SD_MISO
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_PRE, S_SEND, S_WAIT, S_RESP, S_TAIL
  } state_t;

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [15:0] WAIT_LAST = 16'(RESP_TIMEOUT * 8 - 1);

  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  state_t      state;
  logic [7:0]  div_cnt;
  logic [15:0] bit_cnt;
  logic [47:0] shreg;
  logic [39:0] head;

  assign head = {2'b01, CMD_INDEX, CMD_ARG};

  // Sequencer: each bit is a low half then a high half; bits end on SCK fall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      div_cnt <= 8'd0;
      bit_cnt <= 16'd0;
      shreg   <= {48{1'b1}};
      SD_SCK  <= 1'b0;
      SD_CMD  <= 1'b1;
      SD_CS_N <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      R1      <= 8'hFF;
      TIMEOUT <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state == S_IDLE) begin
        div_cnt <= 8'd0;
        bit_cnt <= 16'd0;
        if (INIT_REQ) begin
          state   <= S_INIT;
          BUSY    <= 1'b1;
          TIMEOUT <= 1'b0;
          R1      <= 8'hFF;
        end else if (CMD_REQ) begin
          state   <= S_PRE;
          BUSY    <= 1'b1;
          TIMEOUT <= 1'b0;
          R1      <= 8'hFF;
          SD_CS_N <= 1'b0;
          shreg   <= {head, crc7(head), 1'b1};
        end else begin
          state <= S_IDLE;
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 8'd1;
      end else begin
        div_cnt <= 8'd0;
        if (!SD_SCK) begin
          SD_SCK <= 1'b1;
          // A low sample while waiting is the R1 start bit by definition.
          if ((state == S_WAIT && !SD_MISO) || state == S_RESP) begin
            R1 <= {R1[6:0], SD_MISO};
          end else begin
            R1 <= R1;
          end
        end else begin
          SD_SCK  <= 1'b0;
          bit_cnt <= bit_cnt + 16'd1;
          case (state)
            S_INIT: begin
              if (bit_cnt == 16'd79) begin
                state <= S_IDLE;
                DONE  <= 1'b1;
                BUSY  <= 1'b0;
              end
            end
            S_PRE: begin
              if (bit_cnt == 16'd7) begin
                state   <= S_SEND;
                bit_cnt <= 16'd0;
                SD_CMD  <= shreg[47];
                shreg   <= {shreg[46:0], 1'b1};
              end
            end
            S_SEND: begin
              if (bit_cnt == 16'd47) begin
                state   <= S_WAIT;
                bit_cnt <= 16'd0;
                SD_CMD  <= 1'b1;
              end else begin
                SD_CMD <= shreg[47];
                shreg  <= {shreg[46:0], 1'b1};
              end
            end
            S_WAIT: begin
              // R1 only loses its all-ones value once the start bit is captured.
              if (!R1[0]) begin
                state   <= S_RESP;
                bit_cnt <= 16'd0;
              end else if (bit_cnt == WAIT_LAST) begin
                state   <= S_TAIL;
                bit_cnt <= 16'd0;
              end
            end
            S_RESP: begin
              if (bit_cnt == 16'd6) begin
                state   <= S_TAIL;
                bit_cnt <= 16'd0;
              end
            end
            S_TAIL: begin
              if (bit_cnt == 16'd7) begin
                state   <= S_IDLE;
                SD_CS_N <= 1'b1;
                DONE    <= 1'b1;
                BUSY    <= 1'b0;
                TIMEOUT <= R1[7];
              end
            end
            default: begin
              state <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule
